vga_sprite_engine: RTL and testbench
====================================

VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 SHALL have parameters: HWIDTH 640 (visible pixels/line), HFPORCH 16, HSYNC 96, HBPORCH 48, VWIDTH 480 (visible lines), VFPORCH 10, VSYNC 2, VBPORCH 33, NSPRITES 2 (1..8 circles), RADIUS 30, STEP 5 (base motion, pixels/frame), CW 4 (bits/colour channel).
REQ-002 SHALL have ports: clk in 1 (pixel clock); rst_n in 1 (reset); en in 1 (motion enable); VGA_R/VGA_G/VGA_B out CW (colour); VGA_HS out 1; VGA_VS out 1; VGA_DE out 1 (active video).
REQ-003 SHALL use the single clock clk; rst_n SHALL be asynchronous, active-low.

Function
REQ-004 hcnt SHALL count 0..HTOTAL-1 (HTOTAL=HWIDTH+HFPORCH+HSYNC+HBPORCH) and wrap to 0; vcnt SHALL increment on hcnt wrap, range 0..VTOTAL-1, wrap to 0.
REQ-005 Line/frame order SHALL be: active, front porch, sync, back porch.
REQ-006 VGA_HS SHALL be low (active) when hcnt in [HWIDTH+HFPORCH, HWIDTH+HFPORCH+HSYNC); VGA_VS likewise on vcnt with vertical parameters.
REQ-007 VGA_DE SHALL be high when hcnt<HWIDTH and vcnt<VWIDTH.
REQ-008 VGA_HS, VGA_VS, VGA_DE, RGB SHALL all be registered from the same hcnt/vcnt: uniform 1-cycle latency, mutually aligned.
REQ-009 RGB SHALL be 0 whenever VGA_DE would be 0.
REQ-010 Sprite i SHALL hold centre (x_i, y_i) and direction bits dx_i (0 = right), dy_i (0 = down); step for sprite i SHALL be STEP+i in both axes.
REQ-011 Pixel inside sprite i when (|hcnt-x_i|)^2 + (|vcnt-y_i|)^2 <= RADIUS^2, absolute differences unsigned, sum width sufficient for no overflow.
REQ-012 Pixel priority: border (row 0, row VWIDTH-1, column 0, column HWIDTH-1) > lowest-index covering sprite > background black.
REQ-013 Colours (all-ones = full scale): border blue; sprite i by i mod 4: green, red, yellow, cyan.
REQ-014 Positions SHALL update once per frame, in the cycle hcnt=HTOTAL-1 and vcnt=VTOTAL-1, only if en=1.
REQ-015 X update moving right: if x_i+s+RADIUS > HWIDTH-1 then x_i <= HWIDTH-1-RADIUS, dx_i <= 1; else x_i <= x_i+s. Moving left: if x_i < RADIUS+s then x_i <= RADIUS, dx_i <= 0; else x_i <= x_i-s.
REQ-016 Y update SHALL mirror REQ-015 with VWIDTH and dy_i; x and y updates are independent in the same cycle.
REQ-017 Sprite centres SHALL always satisfy RADIUS <= x_i <= HWIDTH-1-RADIUS, RADIUS <= y_i <= VWIDTH-1-RADIUS.
REQ-018 en change mid-frame SHALL only affect the next update cycle; rendering is unaffected by en.

Reset
REQ-019 While rst_n=0: hcnt=vcnt=0, VGA_HS=VGA_VS=1, VGA_DE=0, RGB=0, dx_i=dy_i=0, x_i=RADIUS+i*(2*RADIUS+2), y_i=RADIUS.
REQ-020 Reset assertion mid-line/mid-frame SHALL force REQ-019 values immediately; after release, timing restarts at hcnt=vcnt=0.
REQ-021 Elaboration SHALL error if NSPRITES is outside 1..8 or any initial x_i exceeds HWIDTH-1-RADIUS.

Configuration
REQ-022 Macro VGA_SPRITE_OVERLAP_EN: when defined, a non-border pixel covered by >=2 sprites SHALL be white (all-ones); when undefined, REQ-012 priority applies unchanged.

Verification
REQ-023 Release reset, defaults -> VGA_HS period 800 clk, low 96 clk; VGA_VS period 420000 clk, low 1600 clk; VGA_DE high 640 clk/line for 480 lines.
REQ-024 First frame, defaults -> pixel (0,0) blue; (30,30) green; (92,30) red; (320,240) black; (700,10) RGB=0.
REQ-025 NSPRITES=1, en=1 -> x_0 reaches 609 in frame 116, then decreases by 5; x_0 never >609 nor <30.
REQ-026 en=0 for 3 frames after 10 moving frames -> x_i,y_i unchanged; en=1 -> motion resumes next frame boundary.
REQ-027 NSPRITES=2, run to first overlap -> overlap pixels green without VGA_SPRITE_OVERLAP_EN, white with it.
REQ-028 rst_n pulsed low at hcnt=100, vcnt=200 -> outputs at reset values in the same cycle; first VGA_HS low 656 clk after release.

Source files
------------

// File: rtl/vga_sprite_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_sprite_engine: VGA timing plus bouncing filled-circle sprites.       |
// | Optional macro VGA_SPRITE_OVERLAP_EN paints multi-sprite pixels white.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_sprite_engine #(
  parameter int HWIDTH   = 640,
  parameter int HFPORCH  = 16,
  parameter int HSYNC    = 96,
  parameter int HBPORCH  = 48,
  parameter int VWIDTH   = 480,
  parameter int VFPORCH  = 10,
  parameter int VSYNC    = 2,
  parameter int VBPORCH  = 33,
  parameter int NSPRITES = 2,
  parameter int RADIUS   = 30,
  parameter int STEP     = 5,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] VGA_R,
  output logic [CW-1:0] VGA_G,
  output logic [CW-1:0] VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE
);

  localparam int HTOTAL   = HWIDTH + HFPORCH + HSYNC + HBPORCH;
  localparam int VTOTAL   = VWIDTH + VFPORCH + VSYNC + VBPORCH;
  localparam int XW       = $clog2(HTOTAL);
  localparam int YW       = $clog2(VTOTAL);
  localparam int DW       = (XW > YW) ? XW : YW;
  localparam int SW       = 2 * DW + 1;
  localparam int HS_START = HWIDTH + HFPORCH;
  localparam int HS_END   = HWIDTH + HFPORCH + HSYNC;
  localparam int VS_START = VWIDTH + VFPORCH;
  localparam int VS_END   = VWIDTH + VFPORCH + VSYNC;
  localparam logic [CW-1:0] ON  = {CW{1'b1}};
  localparam logic [CW-1:0] OFF = {CW{1'b0}};

  generate
    if (NSPRITES < 1 || NSPRITES > 8) begin : g_bad_nsprites
      $error("vga_sprite_engine: NSPRITES must be within 1..8");
    end
    if (RADIUS + (NSPRITES - 1) * (2 * RADIUS + 2) > HWIDTH - 1 - RADIUS) begin : g_bad_layout
      $error("vga_sprite_engine: initial sprite x exceeds HWIDTH-1-RADIUS");
    end
  endgenerate

  logic [XW-1:0]       hcnt;
  logic [YW-1:0]       vcnt;
  logic [31:0]         hx;
  logic [31:0]         vy;
  logic                h_last;
  logic                frame_end;
  logic [NSPRITES-1:0] hit;

  assign hx        = 32'(hcnt);
  assign vy        = 32'(vcnt);
  assign h_last    = (hx == 32'(HTOTAL - 1));
  assign frame_end = h_last && (vy == 32'(VTOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= frame_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NSPRITES; i++) begin : g_sprite
    localparam int S  = STEP + i;
    localparam int X0 = RADIUS + i * (2 * RADIUS + 2);

    logic [XW-1:0] x_pos;
    logic [YW-1:0] y_pos;
    logic          dx;
    logic          dy;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic          dx_nxt;
    logic          dy_nxt;
    logic [31:0]   xe;
    logic [31:0]   ye;
    logic [DW-1:0] adx;
    logic [DW-1:0] ady;
    logic [SW-1:0] d2;

    assign xe = 32'(x_pos);
    assign ye = 32'(y_pos);

    // Unsigned distance from the current scan position to the centre.
    always_comb begin
      adx = (hx >= xe) ? DW'(hx - xe) : DW'(xe - hx);
      ady = (vy >= ye) ? DW'(vy - ye) : DW'(ye - vy);
      d2  = SW'(adx) * SW'(adx) + SW'(ady) * SW'(ady);
    end
    assign hit[i] = (d2 <= SW'(RADIUS * RADIUS));

    // Bounce clamps the centre onto the wall instead of overshooting it.
    always_comb begin
      x_nxt  = x_pos;
      dx_nxt = dx;
      y_nxt  = y_pos;
      dy_nxt = dy;
      if (!dx) begin
        if (xe + 32'(S + RADIUS) > 32'(HWIDTH - 1)) begin
          x_nxt  = XW'(HWIDTH - 1 - RADIUS);
          dx_nxt = 1'b1;
        end else begin
          x_nxt = XW'(xe + 32'(S));
        end
      end else if (xe < 32'(RADIUS + S)) begin
        x_nxt  = XW'(RADIUS);
        dx_nxt = 1'b0;
      end else begin
        x_nxt = XW'(xe - 32'(S));
      end
      if (!dy) begin
        if (ye + 32'(S + RADIUS) > 32'(VWIDTH - 1)) begin
          y_nxt  = YW'(VWIDTH - 1 - RADIUS);
          dy_nxt = 1'b1;
        end else begin
          y_nxt = YW'(ye + 32'(S));
        end
      end else if (ye < 32'(RADIUS + S)) begin
        y_nxt  = YW'(RADIUS);
        dy_nxt = 1'b0;
      end else begin
        y_nxt = YW'(ye - 32'(S));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_pos <= XW'(X0);
        y_pos <= YW'(RADIUS);
        dx    <= 1'b0;
        dy    <= 1'b0;
      end else if (frame_end && en) begin
        x_pos <= x_nxt;
        y_pos <= y_nxt;
        dx    <= dx_nxt;
        dy    <= dy_nxt;
      end
    end
  end

  logic [CW-1:0] r_n;
  logic [CW-1:0] g_n;
  logic [CW-1:0] b_n;
  logic          de_n;
  logic          hs_n;
  logic          vs_n;
  logic          border;
  logic          overlap;

  always_comb begin
    de_n    = (hx < 32'(HWIDTH)) && (vy < 32'(VWIDTH));
    hs_n    = !((hx >= 32'(HS_START)) && (hx < 32'(HS_END)));
    vs_n    = !((vy >= 32'(VS_START)) && (vy < 32'(VS_END)));
    border  = (hx == 32'd0) || (hx == 32'(HWIDTH - 1)) ||
              (vy == 32'd0) || (vy == 32'(VWIDTH - 1));
    overlap = (hit & (hit - NSPRITES'(1))) != '0;
    r_n     = OFF;
    g_n     = OFF;
    b_n     = OFF;
    if (de_n) begin
      if (border) begin
        b_n = ON;
`ifdef VGA_SPRITE_OVERLAP_EN
      end else if (overlap) begin
        r_n = ON;
        g_n = ON;
        b_n = ON;
`endif
      end else begin
        // Scan downward so the lowest-index covering sprite is written last.
        for (int k = NSPRITES - 1; k >= 0; k--) begin
          if (hit[k]) begin
            case (k % 4)
              0:       begin r_n = OFF; g_n = ON;  b_n = OFF; end
              1:       begin r_n = ON;  g_n = OFF; b_n = OFF; end
              2:       begin r_n = ON;  g_n = ON;  b_n = OFF; end
              default: begin r_n = OFF; g_n = ON;  b_n = ON;  end
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_DE <= 1'b0;
    end else begin
      VGA_R  <= r_n;
      VGA_G  <= g_n;
      VGA_B  <= b_n;
      VGA_HS <= hs_n;
      VGA_VS <= vs_n;
      VGA_DE <= de_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_sprite_engine: reference-model bench on a shrunken raster.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vga_sprite_engine;

  localparam int HW = 40, HFP = 2, HSY = 4, HBP = 2;
  localparam int VW = 30, VFP = 1, VSY = 2, VBP = 1;
  localparam int NS = 3, R = 4, STEP = 2, CW = 4;
  localparam int HT = HW + HFP + HSY + HBP;
  localparam int VT = VW + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [CW-1:0] vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, vga_de;

  vga_sprite_engine #(
    .HWIDTH(HW), .HFPORCH(HFP), .HSYNC(HSY), .HBPORCH(HBP),
    .VWIDTH(VW), .VFPORCH(VFP), .VSYNC(VSY), .VBPORCH(VBP),
    .NSPRITES(NS), .RADIUS(R), .STEP(STEP), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_DE(vga_de)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: sprite positions and the raster position about to be output.
  int sx[NS], sy[NS];
  bit sdx[NS], sdy[NS];
  int mh, mv, cur_h, cur_v, last_hits;
  bit saw_overlap;
  logic [11:0] exp_rgb, got_rgb;
  logic exp_hs, exp_vs, exp_de, got_hs, got_vs, got_de;

  function automatic void init_model();
    mh = 0;
    mv = 0;
    for (int i = 0; i < NS; i++) begin
      sx[i] = R + i * (2 * R + 2);
      sy[i] = R;
      sdx[i] = 1'b0;
      sdy[i] = 1'b0;
    end
  endfunction

  function automatic void move_model();
    for (int i = 0; i < NS; i++) begin
      int s = STEP + i;
      if (!sdx[i]) begin
        if (sx[i] + s + R > HW - 1) begin sx[i] = HW - 1 - R; sdx[i] = 1'b1; end
        else sx[i] = sx[i] + s;
      end else begin
        if (sx[i] < R + s) begin sx[i] = R; sdx[i] = 1'b0; end
        else sx[i] = sx[i] - s;
      end
      if (!sdy[i]) begin
        if (sy[i] + s + R > VW - 1) begin sy[i] = VW - 1 - R; sdy[i] = 1'b1; end
        else sy[i] = sy[i] + s;
      end else begin
        if (sy[i] < R + s) begin sy[i] = R; sdy[i] = 1'b0; end
        else sy[i] = sy[i] - s;
      end
    end
  endfunction

  function automatic logic [11:0] model_rgb(int h, int v);
    int first = -1;
    last_hits = 0;
    if (!(h < HW && v < VW)) return 12'h000;
    if (h == 0 || h == HW - 1 || v == 0 || v == VW - 1) return 12'h00F;
    for (int i = 0; i < NS; i++) begin
      int ddx = (h > sx[i]) ? h - sx[i] : sx[i] - h;
      int ddy = (v > sy[i]) ? v - sy[i] : sy[i] - v;
      if (ddx * ddx + ddy * ddy <= R * R) begin
        last_hits++;
        if (first < 0) first = i;
      end
    end
`ifdef VGA_SPRITE_OVERLAP_EN
    if (last_hits >= 2) return 12'hFFF;
`endif
    if (first < 0) return 12'h000;
    case (first % 4)
      0: return 12'h0F0;
      1: return 12'hF00;
      2: return 12'hFF0;
      default: return 12'h0FF;
    endcase
  endfunction

  // Advance one pixel clock: predict, clock, sample, then update the model.
  task automatic step();
    exp_de  = (mh < HW) && (mv < VW);
    exp_hs  = !(mh >= HW + HFP && mh < HW + HFP + HSY);
    exp_vs  = !(mv >= VW + VFP && mv < VW + VFP + VSY);
    exp_rgb = model_rgb(mh, mv);
    if (last_hits >= 2) saw_overlap = 1'b1;
    cur_h = mh;
    cur_v = mv;
    @(posedge clk);
    #1;
    got_rgb = {vga_r, vga_g, vga_b};
    got_hs = vga_hs;
    got_vs = vga_vs;
    got_de = vga_de;
    if (mh == HT - 1 && mv == VT - 1 && en) move_model();
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (vga_hs !== 1'b1) begin failures++; $display("FAIL reset_hs: got %b expected 1", vga_hs); end
    checks++; if (vga_vs !== 1'b1) begin failures++; $display("FAIL reset_vs: got %b expected 1", vga_vs); end
    checks++; if (vga_de !== 1'b0) begin failures++; $display("FAIL reset_de: got %b expected 0", vga_de); end
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL reset_rgb: got %h expected 000", {vga_r, vga_g, vga_b}); end
    rst_n = 1'b1;
    init_model();
  endtask

  task automatic test_first_frame();
    int ph[9] = '{0, 4, 14, 24, 20, 44, 8, 10, 9};
    int pv[9] = '{0, 4, 4, 4, 15, 2, 4, 4, 4};
    logic [11:0] pe[9] = '{12'h00F, 12'h0F0, 12'hF00, 12'hFF0, 12'h000, 12'h000, 12'h0F0, 12'hF00, 12'h000};
    logic [11:0] cap[9];
    int err = 0, bh = 0, bv = 0;
    logic [14:0] bgot = '0, bexp = '0;
    for (int k = 0; k < 9; k++) cap[k] = 12'hxxx;
    for (int p = 0; p < FRAME; p++) begin
      step();
      for (int k = 0; k < 9; k++) if (cur_h == ph[k] && cur_v == pv[k]) cap[k] = got_rgb;
      if ({got_hs, got_vs, got_de, got_rgb} !== {exp_hs, exp_vs, exp_de, exp_rgb}) begin
        if (err == 0) begin bh = cur_h; bv = cur_v; bgot = {got_hs, got_vs, got_de, got_rgb}; bexp = {exp_hs, exp_vs, exp_de, exp_rgb}; end
        err++;
      end
    end
    checks++;
    if (err != 0) begin failures++; $display("FAIL first_frame: %0d bad cycles, first (%0d,%0d) got %h expected %h", err, bh, bv, bgot, bexp); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (cap[k] !== pe[k]) begin failures++; $display("FAIL pixel_%0d_%0d: got %h expected %h", ph[k], pv[k], cap[k], pe[k]); end
    end
  endtask

  task automatic test_motion();
    en = 1'b1;
    saw_overlap = 1'b0;
    for (int f = 0; f < 14; f++) begin
      int err = 0, bh = 0, bv = 0;
      logic [14:0] bgot = '0, bexp = '0;
      for (int p = 0; p < FRAME; p++) begin
        step();
        if ({got_hs, got_vs, got_de, got_rgb} !== {exp_hs, exp_vs, exp_de, exp_rgb}) begin
          if (err == 0) begin bh = cur_h; bv = cur_v; bgot = {got_hs, got_vs, got_de, got_rgb}; bexp = {exp_hs, exp_vs, exp_de, exp_rgb}; end
          err++;
        end
      end
      checks++;
      if (err != 0) begin failures++; $display("FAIL motion_frame%0d: %0d bad cycles, first (%0d,%0d) got %h expected %h", f, err, bh, bv, bgot, bexp); end
    end
    checks++;
    if (saw_overlap !== 1'b1) begin failures++; $display("FAIL overlap_reached: got %b expected 1", saw_overlap); end
  endtask

  task automatic test_en_hold();
    for (int f = 0; f < 11; f++) begin
      int err = 0, bh = 0, bv = 0;
      logic [14:0] bgot = '0, bexp = '0;
      for (int p = 0; p < FRAME; p++) begin
        // en toggles mid-frame too; only its value at the frame's last pixel matters.
        if (p == FRAME / 2) en = (f < 3) ? 1'b1 : 1'($urandom);
        if (p == 0) en = (f < 3) ? 1'b0 : (f < 5) ? 1'b1 : 1'($urandom);
        step();
        if ({got_hs, got_vs, got_de, got_rgb} !== {exp_hs, exp_vs, exp_de, exp_rgb}) begin
          if (err == 0) begin bh = cur_h; bv = cur_v; bgot = {got_hs, got_vs, got_de, got_rgb}; bexp = {exp_hs, exp_vs, exp_de, exp_rgb}; end
          err++;
        end
        if (p == FRAME - 2) en = (f < 3) ? 1'b0 : en;
      end
      checks++;
      if (err != 0) begin failures++; $display("FAIL en_frame%0d: %0d bad cycles, first (%0d,%0d) got %h expected %h", f, err, bh, bv, bgot, bexp); end
    end
  endtask

  task automatic test_reset_midframe();
    int guard = 0, k = 0, err = 0;
    en = 1'b1;
    while (!(cur_h == 20 && cur_v == 10) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 2 * FRAME) begin failures++; $display("FAIL midframe_reach: got timeout expected pixel (20,10)"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b} !== {3'b110, 12'h000}) begin
      failures++; $display("FAIL midframe_reset_outputs: got %h expected %h", {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}, {3'b110, 12'h000});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b} !== {3'b110, 12'h000}) begin
      failures++; $display("FAIL midframe_reset_hold: got %h expected %h", {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}, {3'b110, 12'h000});
    end
    rst_n = 1'b1;
    init_model();
    for (k = 0; k < 2 * HT; k++) begin
      step();
      if (!got_hs) break;
    end
    checks++;
    if (k != HW + HFP) begin failures++; $display("FAIL hs_after_release: got edge %0d expected %0d", k, HW + HFP); end
    for (int p = k + 1; p < FRAME; p++) begin
      step();
      if ({got_hs, got_vs, got_de, got_rgb} !== {exp_hs, exp_vs, exp_de, exp_rgb}) err++;
    end
    checks++;
    if (err != 0) begin failures++; $display("FAIL post_reset_frame: got %0d bad cycles expected 0", err); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_motion();
    test_en_hold();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
